brq_lsu_resp: RTL and testbench



---
 rtl/brq_lsu_resp.sv | 242 ++++++++++++++++++++++++
 tb/tb_brq_lsu_resp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brq_lsu_resp.sv
// ---------------------------------------------------------------------------
// brq_lsu_resp -- data-side load/store engine
//
// Accepts one load/store at a time from ID/EX and runs a single
// request/grant/rvalid transaction on the data bus. Load data is aligned
// and extended. Exactly one response is reported per accepted request.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   lsu_req_i .. lsu_wdata_i   request from ID/EX (sampled in IDLE only)
//   lsu_busy_o                 engine not idle
//   data_*                     data bus (req/gnt/rvalid handshake)
//   rf_wdata_lsu_o             aligned/extended load data
//   rf_we_lsu_o                load write-back enable
//   lsu_resp_valid_o           one-cycle response pulse
//   lsu_resp_err_o             response is an error
//   fp_load_o                  write-back targets the FP register file
// ---------------------------------------------------------------------------
module brq_lsu_resp #(
    parameter int unsigned TimeoutCycles = 0,
    parameter bit          CheckAlign    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic        lsu_fp_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        fp_load_o
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        ERR_RESP    = 2'd3
    } state_e;

    // Last WAIT_RVALID cycle index before a forced error response.
    localparam logic [31:0] TO_LAST = (TimeoutCycles == 32'd0) ? 32'd0 : (TimeoutCycles - 32'd1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic        sext_q, sext_d;
    logic        fp_q, fp_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cnt_q, cnt_d;

    logic        misaligned_s;
    logic [1:0]  off_s;
    logic        resp_valid_s;
    logic        resp_err_s;
    logic        rf_we_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_s;

    // Alignment check and effective byte offset of the incoming request.
    always_comb begin
        misaligned_s = 1'b0;
        off_s        = lsu_addr_i[1:0];
        case (lsu_type_i)
            2'b10: begin
                misaligned_s = 1'b0;
                off_s        = lsu_addr_i[1:0];
            end
            2'b01: begin
                misaligned_s = lsu_addr_i[0];
                // With checking off, the low address bit is simply dropped.
                off_s        = {lsu_addr_i[1], 1'b0};
            end
            default: begin
                misaligned_s = (lsu_addr_i[1:0] != 2'b00);
                off_s        = 2'b00;
            end
        endcase
    end

    // Next-state, request capture and response generation.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        type_d       = type_q;
        sext_d       = sext_q;
        fp_d         = fp_q;
        off_d        = off_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        resp_valid_s = 1'b0;
        resp_err_s   = 1'b0;
        rf_we_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    we_d   = lsu_we_i;
                    type_d = lsu_type_i;
                    sext_d = lsu_sign_ext_i;
                    fp_d   = lsu_fp_i;
                    off_d  = off_s;
                    addr_d = lsu_addr_i[31:2];
                    case (lsu_type_i)
                        2'b10: begin
                            be_d    = 4'b0001 << off_s;
                            wdata_d = {4{lsu_wdata_i[7:0]}};
                        end
                        2'b01: begin
                            be_d    = 4'b0011 << {off_s[1], 1'b0};
                            wdata_d = {2{lsu_wdata_i[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = lsu_wdata_i;
                        end
                    endcase
                    if (CheckAlign && misaligned_s) begin
                        state_d = ERR_RESP;
                    end else begin
                        state_d = WAIT_GNT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_GNT: begin
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                    cnt_d   = 32'd0;
                end else begin
                    state_d = WAIT_GNT;
                end
            end
            WAIT_RVALID: begin
                // rvalid takes priority over a timeout in the same cycle.
                if (data_rvalid_i) begin
                    resp_valid_s = 1'b1;
                    resp_err_s   = data_err_i;
                    rf_we_s      = ~we_q & ~data_err_i;
                    state_d      = IDLE;
                end else if ((TimeoutCycles != 32'd0) && (cnt_q == TO_LAST)) begin
                    resp_valid_s = 1'b1;
                    resp_err_s   = 1'b1;
                    state_d      = IDLE;
                end else if (TimeoutCycles != 32'd0) begin
                    cnt_d = cnt_q + 32'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ERR_RESP: begin
                resp_valid_s = 1'b1;
                resp_err_s   = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            type_q  <= 2'b00;
            sext_q  <= 1'b0;
            fp_q    <= 1'b0;
            off_q   <= 2'b00;
            addr_q  <= 30'd0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sext_q  <= sext_d;
            fp_q    <= fp_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load data alignment and extension, driven straight from the bus.
    always_comb begin
        case (off_q)
            2'b00:   byte_s = data_rdata_i[7:0];
            2'b01:   byte_s = data_rdata_i[15:8];
            2'b10:   byte_s = data_rdata_i[23:16];
            default: byte_s = data_rdata_i[31:24];
        endcase
        if (off_q[1]) begin
            half_s = data_rdata_i[31:16];
        end else begin
            half_s = data_rdata_i[15:0];
        end
        case (type_q)
            2'b10:   load_s = {{24{sext_q & byte_s[7]}}, byte_s};
            2'b01:   load_s = {{16{sext_q & half_s[15]}}, half_s};
            default: load_s = data_rdata_i;
        endcase
    end

    assign lsu_busy_o       = (state_q != IDLE);
    assign data_req_o       = (state_q == WAIT_GNT);
    assign data_addr_o      = {addr_q, 2'b00};
    assign data_we_o        = we_q;
    assign data_be_o        = be_q;
    assign data_wdata_o     = wdata_q;
    assign rf_wdata_lsu_o   = load_s;
    assign rf_we_lsu_o      = rf_we_s;
    assign lsu_resp_valid_o = resp_valid_s;
    assign lsu_resp_err_o   = resp_err_s;
    assign fp_load_o        = fp_q & rf_we_s;

endmodule

// File: tb/tb_brq_lsu_resp.sv
module tb_brq_lsu_resp;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i, lsu_fp_i;
    logic [1:0]  lsu_type_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_busy_o, data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i, rf_wdata_lsu_o;
    logic [3:0]  data_be_o;
    logic        rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o, fp_load_o;

    always #5 clk = ~clk;

    brq_lsu_resp #(.TimeoutCycles(TO), .CheckAlign(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
        .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_fp_i(lsu_fp_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_busy_o(lsu_busy_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .rf_wdata_lsu_o(rf_wdata_lsu_o), .rf_we_lsu_o(rf_we_lsu_o),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o),
        .fp_load_o(fp_load_o)
    );

    typedef struct packed {
        logic        err;
        logic        rf_we;
        logic [31:0] wd;
        logic        fp;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Expected bus request while the engine should be requesting.
    logic        exp_bus = 1'b0;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic        exp_we;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic is_mis(logic [1:0] ty, logic [31:0] a);
        if (ty == 2'd1) return (a % 2) != 0;
        if (ty == 2'd2) return 1'b0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] ty, logic sx, logic [31:0] a, logic [31:0] rd);
        logic [31:0] v;
        if (ty == 2'd2) begin
            v = (rd >> (8 * (a % 4))) & 32'h0000_00FF;
            if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (ty == 2'd1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
            if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Bus monitor: request must match expectation exactly.
    always @(negedge clk) begin
        if (!rst_i && (exp_bus || data_req_o)) begin
            chk("data_req", 32'(data_req_o), 32'(exp_bus));
            if (exp_bus && data_req_o) begin
                chk("data_addr", data_addr_o, exp_addr);
                chk("data_be", 32'(data_be_o), 32'(exp_be));
                chk("data_wdata", data_wdata_o, exp_wd);
                chk("data_we", 32'(data_we_o), 32'(exp_we));
            end
        end
    end

    // Response monitor: every response pops one expectation.
    always @(negedge clk) begin
        if (lsu_resp_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp_valid=1 err=%0b expected no response", lsu_resp_err_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_err", 32'(lsu_resp_err_o), 32'(e.err));
                chk("rf_we", 32'(rf_we_lsu_o), 32'(e.rf_we));
                if (e.rf_we) begin
                    chk("rf_wdata", rf_wdata_lsu_o, e.wd);
                    chk("fp_load", 32'(fp_load_o), 32'(e.fp));
                end else begin
                    chk("fp_load_idle", 32'(fp_load_o), 32'd0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(string tag);
        @(negedge clk);
        chk({tag, "_req"}, 32'(data_req_o), 32'd0);
        chk({tag, "_busy"}, 32'(lsu_busy_o), 32'd0);
        chk({tag, "_resp"}, 32'(lsu_resp_valid_o), 32'd0);
        chk({tag, "_rfwe"}, 32'(rf_we_lsu_o), 32'd0);
        chk({tag, "_fp"}, 32'(fp_load_o), 32'd0);
    endtask

    // One transaction; starts and ends #1 after a clock edge with DUT idle.
    task automatic do_txn(logic we, logic [1:0] ty, logic sx, logic fp, logic [31:0] a,
                          logic [31:0] wd, logic [31:0] rd, logic er, int g, int r, logic to);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = ty; lsu_sign_ext_i = sx;
        lsu_fp_i = fp; lsu_addr_i = a; lsu_wdata_i = wd;
        step();
        lsu_req_i = 1'b0; lsu_we_i = 1'($urandom); lsu_type_i = 2'($urandom);
        lsu_addr_i = $urandom; lsu_wdata_i = $urandom; lsu_fp_i = 1'($urandom);
        if (is_mis(ty, a)) begin
            exp_q.push_back('{err: 1'b1, rf_we: 1'b0, wd: 32'd0, fp: 1'b0});
            @(negedge clk);
            chk("resp_timing_mis", 32'(lsu_resp_valid_o), 32'd1);
            step();
            return;
        end
        exp_addr = a & 32'hFFFF_FFFC;
        exp_we   = we;
        if (ty == 2'd2) begin
            exp_be = 4'(32'd1 << (a % 4));
            exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        end else if (ty == 2'd1) begin
            exp_be = 4'(32'd3 << (a & 32'd2));
            exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        end else begin
            exp_be = 4'hF;
            exp_wd = wd;
        end
        exp_bus = 1'b1;
        for (int i = 0; i < g; i++) begin
            data_rvalid_i = 1'($urandom);   // ignored while waiting for grant
            data_err_i    = 1'($urandom);
            step();
        end
        data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
        step();
        data_gnt_i = 1'b0; exp_bus = 1'b0;
        if (to) begin
            repeat (TO - 1) step();
            exp_q.push_back('{err: 1'b1, rf_we: 1'b0, wd: 32'd0, fp: 1'b0});
            @(negedge clk);
            chk("resp_timing_to", 32'(lsu_resp_valid_o), 32'd1);
            step();
            data_rvalid_i = 1'b1; data_err_i = 1'($urandom);  // stray, must be ignored
            step();
            data_rvalid_i = 1'b0; data_err_i = 1'b0;
            return;
        end
        repeat (r) step();
        data_rvalid_i = 1'b1; data_err_i = er; data_rdata_i = rd;
        exp_q.push_back('{err: er, rf_we: (!we && !er), wd: ref_load(ty, sx, a, rd), fp: fp});
        @(negedge clk);
        chk("resp_timing", 32'(lsu_resp_valid_o), 32'd1);
        step();
        data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = $urandom;
    endtask

    initial begin
        rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'd0;
        lsu_sign_ext_i = 1'b0; lsu_fp_i = 1'b0; lsu_addr_i = 32'd0; lsu_wdata_i = 32'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'd0;
        repeat (3) step();
        // Reset state: every output zero (read data held at zero).
        @(negedge clk);
        chk("rst_addr", data_addr_o, 32'd0);
        chk("rst_be", 32'(data_be_o), 32'd0);
        chk("rst_wdata", data_wdata_o, 32'd0);
        chk("rst_we", 32'(data_we_o), 32'd0);
        chk("rst_rfwdata", rf_wdata_lsu_o, 32'd0);
        chk("rst_err", 32'(lsu_resp_err_o), 32'd0);
        step();
        rst_i = 1'b0;
        check_idle_outputs("rst");
        step();

        // Directed cases.
        do_txn(1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0);
        do_txn(1'b0, 2'd2, 1'b1, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 1'b0, 0, 0, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_FFFF, 1'b0, 1, 1, 1'b0);
        do_txn(1'b1, 2'd1, 1'b0, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1'b0, 3, 0, 1'b0);
        do_txn(1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_3001, 32'd0, 32'd0, 1'b0, 0, 0, 1'b0);
        do_txn(1'b0, 2'd0, 1'b0, 1'b1, 32'h0000_4000, 32'd0, 32'h1111_2222, 1'b1, 0, 1, 1'b0);
        do_txn(1'b0, 2'd0, 1'b0, 1'b0, 32'h0000_5000, 32'd0, 32'd0, 1'b0, 1, 0, 1'b1);
        do_txn(1'b0, 2'd1, 1'b1, 1'b1, 32'h0000_6002, 32'd0, 32'h9876_0000, 1'b0, 0, 3, 1'b0);
        do_txn(1'b0, 2'd3, 1'b0, 1'b1, 32'h0000_7000, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 2, 1'b0);

        // Reset while waiting for grant: request abandoned, no response ever.
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = 2'd0; lsu_fp_i = 1'b1;
        lsu_addr_i = 32'h0000_8000; lsu_wdata_i = 32'd0;
        step();
        lsu_req_i = 1'b0;
        exp_addr = 32'h0000_8000; exp_be = 4'hF; exp_wd = 32'd0; exp_we = 1'b0; exp_bus = 1'b1;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; exp_bus = 1'b0; data_rdata_i = 32'd0;
        check_idle_outputs("midrst");
        step();
        data_rvalid_i = 1'b1; data_gnt_i = 1'b1;
        step();
        data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
        check_idle_outputs("stray");
        step();

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  ty;
            logic [31:0] a;
            ty = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(9, 0) < 7) begin
                if (ty == 2'd1) a = a & 32'hFFFF_FFFE;
                else if (ty != 2'd2) a = a & 32'hFFFF_FFFC;
            end
            do_txn(1'($urandom), ty, 1'($urandom), 1'($urandom), a, $urandom, $urandom,
                   ($urandom_range(3, 0) == 0), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), ($urandom_range(9, 0) == 0));
        end

        repeat (5) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
